out_port_handshake: RTL and testbench

- Memory-mapped output port on the E100 tristate bus: CPU writes to port_number are queued in a small FIFO.
- Queued words are sent one at a time to an external device over a four-phase req/ack handshake.
- A status word at port_number+1 lets software poll fullness, busy and overflow.
- Companion to the input port: the same bus-side decode, in the CPU-to-pins direction.

---
 rtl/e100_port_defs.sv | 34 +++
 rtl/out_port_fifo.sv | 58 +++++
 rtl/sync_2ff.sv | 21 ++
 rtl/out_port_handshake.sv | 121 ++++++++++++
 tb/tb_out_port_handshake.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/e100_port_defs.sv
// Shared definitions for the E100 memory-mapped port blocks: handshake FSM
// encodings, status word layout and a helper that packs the status word.
package e100_port_defs;

    typedef logic [1:0] port_state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] ACK_LOW = 2'd2;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_BUSY      = 3;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic       busy,
        input logic [4:0] count
    );
        logic [31:0] s;
        s                        = '0;
        s[STAT_EMPTY]            = empty;
        s[STAT_FULL]             = full;
        s[STAT_OVF]              = ovf;
        s[STAT_BUSY]             = busy;
        s[STAT_COUNT_LSB +: 5]   = count;
        return s;
    endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Small power-of-two FIFO: synchronous push/pop, head read straight from the
// storage registers, occupancy count with full/empty flags.
module out_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clock domain.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/out_port_handshake.sv
// E100 bus output port: CPU writes are queued and sent over a 4-phase req/ack
// handshake. Define OUT_PORT_ACK_SYNC_EN to pass port_ack through a 2-flop sync.
//
//   state   | meaning
//   IDLE    | no word in flight; pops the FIFO head as soon as it is non-empty
//   REQ     | word on port_pins, port_req high, waiting for ack_s high
//   ACK_LOW | port_req dropped, waiting for the device to release ack
module out_port_handshake
    import e100_port_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      port_number,
    input  logic [31:0]      address,
    input  logic             memory_write,
    input  logic             memory_drive,
    inout  wire  [31:0]      bus,
    output logic [WIDTH-1:0] port_pins,
    output logic             port_req,
    input  logic             port_ack
);

    localparam int CW = $clog2(DEPTH) + 1;

    port_state_t      state;
    logic             ack_s;
    logic             data_hit;
    logic             stat_hit;
    logic             wr_data;
    logic             wr_stat;
    logic             pop;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic [31:0]      status;

`ifdef OUT_PORT_ACK_SYNC_EN
    sync_2ff u_ack_sync (
        .clock (clock),
        .reset (reset),
        .d     (port_ack),
        .q     (ack_s)
    );
`else
    assign ack_s = port_ack;
`endif

    assign data_hit = (address == port_number);
    assign stat_hit = (address == (port_number + 32'd1));
    assign wr_data  = memory_write && data_hit;
    assign wr_stat  = memory_write && stat_hit;
    assign pop      = (state == IDLE) && !empty;

    out_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_data),
        .push_data (bus[WIDTH-1:0]),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Clearing from the status address wins over a same-cycle drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_stat) begin
            overflow <= 1'b0;
        end else if (wr_data && full && !pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            port_pins <= '0;
            port_req  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        port_pins <= head;
                        port_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        port_req <= 1'b0;
                        state    <= ACK_LOW;
                    end
                end
                ACK_LOW: begin
                    if (!ack_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    port_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign status = pack_status(empty, full, overflow, (state != IDLE), 5'(count));
    assign bus    = (memory_drive && stat_hit) ? status : {32{1'bz}};

endmodule

// File: tb/tb_out_port_handshake.sv
// Bench for out_port_handshake (WIDTH=8, DEPTH=4): directed handshake, overflow
// and reset cases, then random traffic checked against a queue model.
module tb_out_port_handshake;

    localparam int          WIDTH = 8;
    localparam int          DEPTH = 4;
    localparam logic [31:0] DATA_ADDR = 32'h8000_0010;
    localparam logic [31:0] STAT_ADDR = 32'h8000_0011;
`ifdef OUT_PORT_ACK_SYNC_EN
    localparam int          ACK_LAT = 3;
`else
    localparam int          ACK_LAT = 1;
`endif

    logic             clock;
    logic             reset;
    logic [31:0]      address;
    logic             memory_write;
    logic             memory_drive;
    wire  [31:0]      bus;
    logic [WIDTH-1:0] port_pins;
    logic             port_req;
    logic             port_ack;

    logic             tb_bus_en;
    logic [31:0]      tb_bus_val;
    logic             dev_auto;
    logic             dev_ack;
    logic             man_ack;

    int               errors;
    int               checks;
    int               n_req;
    logic [7:0]       rx_q[$];
    logic [7:0]       exp_q[$];

    assign bus      = tb_bus_en ? tb_bus_val : {32{1'bz}};
    assign port_ack = dev_auto ? dev_ack : man_ack;

    out_port_handshake #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .port_number  (DATA_ADDR),
        .address      (address),
        .memory_write (memory_write),
        .memory_drive (memory_drive),
        .bus          (bus),
        .port_pins    (port_pins),
        .port_req     (port_req),
        .port_ack     (port_ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address      = a;
        tb_bus_val   = d;
        tb_bus_en    = 1'b1;
        memory_write = 1'b1;
        @(negedge clock);
        memory_write = 1'b0;
        tb_bus_en    = 1'b0;
        address      = 32'h0;
    endtask

    task automatic status_read(output logic [31:0] v);
        address      = STAT_ADDR;
        memory_drive = 1'b1;
        #1;
        v            = bus;
        memory_drive = 1'b0;
        address      = 32'h0;
    endtask

    function automatic logic [31:0] exp_status(input int occ, input logic ovf, input logic busy);
        return (occ << 8) | (32'(busy) << 3) | (32'(ovf) << 2)
             | (32'(occ == DEPTH) << 1) | 32'(occ == 0);
    endfunction

    // Device: acks a random number of cycles after req, releases when req drops.
    initial begin : device
        int cnt;
        int dly;
        cnt     = 0;
        dly     = 2;
        dev_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (reset || !dev_auto) begin
                dev_ack = 1'b0;
                cnt     = 0;
            end else if (port_req && !dev_ack) begin
                if (cnt >= dly) begin
                    dev_ack = 1'b1;
                    cnt     = 0;
                    dly     = $urandom_range(0, 4);
                end else begin
                    cnt++;
                end
            end else if (!port_req && dev_ack) begin
                dev_ack = 1'b0;
            end
        end
    end

    // Records each word at its req rise and checks the pins hold while req is high.
    initial begin : monitor
        logic       prev;
        logic [7:0] held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (port_req && !prev) begin
                    rx_q.push_back(port_pins);
                    held = port_pins;
                    n_req++;
                end else if (port_req && prev) begin
                    check_eq("pins_hold", 32'(port_pins), 32'(held));
                end
                prev = port_req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] st;
        logic [7:0]  t3_exp[6];
        int          n;
        int          base;
        int          n_wr;
        int          occ;
        logic [31:0] d;

        errors       = 0;
        checks       = 0;
        n_req        = 0;
        reset        = 1'b1;
        address      = 32'h0;
        memory_write = 1'b0;
        memory_drive = 1'b0;
        tb_bus_en    = 1'b0;
        tb_bus_val   = 32'h0;
        dev_auto     = 1'b0;
        man_ack      = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        status_read(st);
        check_eq("rst_status", st, 32'h0000_0001);
        check_eq("rst_req", 32'(port_req), 32'h0);
        check_eq("rst_pins", 32'(port_pins), 32'h0);
        address      = DATA_ADDR;
        memory_drive = 1'b1;
        #1;
        check_eq("data_read_float", 32'(bus === {32{1'bz}}), 32'h1);
        memory_drive = 1'b0;
        address      = 32'h0;

        // Single word, manual ack
        bus_write(DATA_ADDR, 32'hFFFF_FFA5);
        check_eq("t2_req_early", 32'(port_req), 32'h0);
        @(negedge clock);
        check_eq("t2_req_rise", 32'(port_req), 32'h1);
        check_eq("t2_pins", 32'(port_pins), 32'hA5);
        repeat (3) @(negedge clock);
        check_eq("t2_req_held", 32'(port_req), 32'h1);
        man_ack = 1'b1;
        n = 0;
        while (port_req && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("t2_ack_latency", 32'(n), 32'(ACK_LAT));
        @(negedge clock);
        status_read(st);
        check_eq("t2_busy_ack_high", st, exp_status(0, 1'b0, 1'b1));
        man_ack = 1'b0;
        repeat (4) @(negedge clock);
        status_read(st);
        check_eq("t2_idle_status", st, 32'h0000_0001);
        check_eq("t2_pins_kept", 32'(port_pins), 32'hA5);

        // Fill to full with ack held low, overflow, clear, write-with-pop
        rx_q.delete();
        for (int i = 0; i < 5; i++) begin
            bus_write(DATA_ADDR, 32'h11 + 32'(i));
        end
        status_read(st);
        check_eq("t3_full_status", st, exp_status(4, 1'b0, 1'b1));
        check_eq("t3_pins_first", 32'(port_pins), 32'h11);
        bus_write(DATA_ADDR, 32'h16);
        status_read(st);
        check_eq("t3_overflow", st, exp_status(4, 1'b1, 1'b1));
        bus_write(STAT_ADDR, $urandom);
        status_read(st);
        check_eq("t3_ovf_clear", st, exp_status(4, 1'b0, 1'b1));
        man_ack = 1'b1;
        n = 0;
        while (port_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("t3_req_fall", 32'(port_req), 32'h0);
        man_ack = 1'b0;
        n = 0;
        status_read(st);
        while (st[3] && n < 20) begin
            @(negedge clock);
            status_read(st);
            n++;
        end
        check_eq("t3_idle_seen", 32'(st[3]), 32'h0);
        bus_write(DATA_ADDR, 32'h17);
        status_read(st);
        check_eq("t3_push_pop_full", st, exp_status(4, 1'b0, 1'b1));
        check_eq("t3_pins_second", 32'(port_pins), 32'h12);
        dev_auto = 1'b1;
        n = 0;
        while (rx_q.size() < 6 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check_eq("t3_rx_count", 32'(rx_q.size()), 32'd6);
        t3_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h17};
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            check_eq("t3_rx_order", 32'(rx_q[i]), 32'(t3_exp[i]));
        end
        n = 0;
        status_read(st);
        while (st != 32'h1 && n < 50) begin
            @(negedge clock);
            status_read(st);
            n++;
        end
        check_eq("t3_drained", st, 32'h0000_0001);

        // Reset in the middle of a handshake with two words queued
        dev_auto = 1'b0;
        man_ack  = 1'b0;
        @(negedge clock);
        bus_write(DATA_ADDR, 32'h21);
        bus_write(DATA_ADDR, 32'h22);
        bus_write(DATA_ADDR, 32'h23);
        status_read(st);
        check_eq("t4_pre_status", st, exp_status(2, 1'b0, 1'b1));
        reset = 1'b1;
        #1;
        check_eq("t4_req_async", 32'(port_req), 32'h0);
        check_eq("t4_pins_async", 32'(port_pins), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        status_read(st);
        check_eq("t4_status", st, 32'h0000_0001);
        repeat (10) @(negedge clock);
        check_eq("t4_no_req", 32'(port_req), 32'h0);

        // Random traffic against the queue model
        dev_auto = 1'b1;
        rx_q.delete();
        exp_q.delete();
        base = n_req;
        n_wr = 0;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            occ = n_wr - (n_req - base);
            if ($urandom_range(0, 2) == 0) begin
                status_read(st);
                check_eq("rnd_status", st & ~32'h8, exp_status(occ, 1'b0, 1'b0));
            end
            if (occ < DEPTH) begin
                d = $urandom;
                bus_write(DATA_ADDR, d);
                exp_q.push_back(d[7:0]);
                n_wr++;
            end else begin
                @(negedge clock);
            end
        end
        n = 0;
        while ((n_req - base) < n_wr && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_eq("rnd_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check_eq("rnd_rx_data", 32'(rx_q[i]), 32'(exp_q[i]));
        end
        n = 0;
        status_read(st);
        while (st != 32'h1 && n < 50) begin
            @(negedge clock);
            status_read(st);
            n++;
        end
        check_eq("rnd_final_status", st, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
